// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame constants.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;
  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned STOP_BITS        = 1;

  // IDLE..STOP match the transmitter's encoding; RECOVER is receive-only.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification, mid-bit sampling, stop-bit check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  logic rxs;

  uart_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0]    shift_q, shift_d;
  logic [DATA_BITS-1:0]    data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d;
  logic                    busy_q;

  logic cnt_half_c;
  logic cnt_last_c;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx),
    .q_o  (rxs)
  );

  assign cnt_half_c = (cnt_q == CNT_W'(HALF - 1));
  assign cnt_last_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Next-state, counter and strobe logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_half_c) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_last_c) begin
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          cnt_d   = '0;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_last_c) begin
          cnt_d = '0;
          if (rxs) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RECOVER;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RECOVER: begin
        // A held-low break line must see a high level before re-arming.
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_q != IDLE);
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  int         v_cyc[$];
  logic [7:0] v_dat[$];
  int         f_cyc[$];
  int         both_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[4];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .data_out (data_out),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe cycle with the edge number that launched it.
  always @(negedge clk) begin
    if (valid) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(data_out);
    end
    if (frame_err) f_cyc.push_back(cyc);
    if (valid && frame_err) both_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Call at a rising-edge time; leaves the stop level on the line.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int e0);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    e0 = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      rx = fr[k];
      if (k == 0) e0 = cyc + 1;
      repeat (CPB) @(posedge clk);
    end
  endtask

  task automatic run_good(input logic [7:0] b, input string name);
    int nv;
    int nf;
    int e0;
    nv = v_cyc.size();
    nf = f_cyc.size();
    @(posedge clk);
    send_frame(b, 1'b1, e0);
    repeat (30) @(posedge clk);
    #1;
    chk({name, "_vcount"}, v_cyc.size(), nv + 1);
    chk({name, "_fcount"}, f_cyc.size(), nf);
    chk({name, "_dout"}, int'(data_out), int'(b));
    if (v_cyc.size() > nv) chk({name, "_latency"}, v_cyc[nv] - e0, 154);
  endtask

  initial begin
    int nv;
    int nf;
    int e0;
    int e1;
    logic [9:0] fr;
    int dur[10];

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C};
    vecs[2] = '{8'h5A, 1'b0, 1'b0, 1'b1, 8'h3C};
    vecs[3] = '{8'h11, 1'b1, 1'b1, 1'b0, 8'h11};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", int'(data_out), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Table-driven frames, including a bad stop bit followed by a long break
    for (int i = 0; i < 4; i++) begin
      nv = v_cyc.size();
      nf = f_cyc.size();
      @(posedge clk);
      send_frame(vecs[i].data, vecs[i].stop, e0);
      if (!vecs[i].stop) begin
        repeat (100) @(posedge clk);
        #1;
        chk($sformatf("vec%0d_break_busy", i), int'(busy), 1);
        chk($sformatf("vec%0d_break_dout", i), int'(data_out), int'(vecs[i].exp_dout));
      end else begin
        #1;
      end
      rx = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_vcount", i), v_cyc.size(), nv + int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_fcount", i), f_cyc.size(), nf + int'(vecs[i].exp_ferr));
      chk($sformatf("vec%0d_dout", i), int'(data_out), int'(vecs[i].exp_dout));
      chk($sformatf("vec%0d_busy_after", i), int'(busy), 0);
      if (vecs[i].exp_valid && v_cyc.size() > nv) begin
        chk($sformatf("vec%0d_vlatency", i), v_cyc[nv] - e0, 154);
        chk($sformatf("vec%0d_vdata", i), int'(v_dat[nv]), int'(vecs[i].data));
      end
      if (vecs[i].exp_ferr && f_cyc.size() > nf) begin
        chk($sformatf("vec%0d_flatency", i), f_cyc[nf] - e0, 154);
      end
    end

    // Glitch: three low cycles are rejected as a start bit
    nv = v_cyc.size();
    nf = f_cyc.size();
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("glitch_vcount", v_cyc.size(), nv);
    chk("glitch_fcount", f_cyc.size(), nf);
    chk("glitch_dout", int'(data_out), 8'h11);
    chk("glitch_busy", int'(busy), 0);
    run_good(8'h3C, "post_glitch");

    // Back-to-back frames with no idle gap
    nv = v_cyc.size();
    @(posedge clk);
    send_frame(8'h00, 1'b1, e0);
    send_frame(8'hFF, 1'b1, e1);
    repeat (30) @(posedge clk);
    #1;
    chk("b2b_vcount", v_cyc.size(), nv + 2);
    if (v_cyc.size() >= nv + 2) begin
      chk("b2b_spacing", v_cyc[nv+1] - v_cyc[nv], 160);
      chk("b2b_first", int'(v_dat[nv]), 8'h00);
      chk("b2b_second", int'(v_dat[nv+1]), 8'hFF);
    end
    chk("b2b_dout", int'(data_out), 8'hFF);

    // Reset asserted halfway through bit 4 of 0xC3, held until the frame ends
    nv = v_cyc.size();
    nf = f_cyc.size();
    fr = {1'b1, 8'hC3, 1'b0};
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      #1;
      rx = fr[k];
      if (k == 5) begin
        repeat (CPB / 2) @(posedge clk);
        #1;
        chk("midrst_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_dout", int'(data_out), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_ferr", int'(frame_err), 0);
        chk("midrst_busy", int'(busy), 0);
        repeat (CPB / 2) @(posedge clk);
      end else begin
        repeat (CPB) @(posedge clk);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_valid", v_cyc.size(), nv);
    chk("midrst_no_ferr", f_cyc.size(), nf);
    chk("midrst_dout_after", int'(data_out), 0);
    run_good(8'h7E, "post_rst");

    // 0x81 with every bit edge shifted by one cycle early or late
    dur = '{17, 14, 18, 14, 18, 14, 18, 14, 18, 15};
    nv = v_cyc.size();
    nf = f_cyc.size();
    fr = {1'b1, 8'h81, 1'b0};
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      #1;
      rx = fr[k];
      repeat (dur[k]) @(posedge clk);
    end
    repeat (30) @(posedge clk);
    #1;
    chk("jitter_vcount", v_cyc.size(), nv + 1);
    chk("jitter_fcount", f_cyc.size(), nf);
    chk("jitter_dout", int'(data_out), 8'h81);

    chk("strobes_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Serial receiver for the UART link; the receive-side counterpart of the existing transmitter.
- Function: synchronises the asynchronous `rx` line, detects and qualifies the start bit, then samples 8 data bits LSB-first at mid-bit.
- Checks the stop bit, then presents the byte on a parallel port with a one-cycle `valid` strobe.
- Consumers: the command decoder and loopback logic.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clocks per serial bit. Legal values are even and ≥ 4.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `rx`  in  1  serial line. Idle high, 8N1 framing, LSB first; asynchronous to `clk`.
- `data_out`  out  8  last correctly framed byte; held until the next good frame.
- `valid`  out  1  one-cycle pulse when `data_out` is updated.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- **Synchroniser:** `rx` passes through 2 flops, both reset to 1. All logic below uses the synchronised value `rxs`.
- **Constants:** HALF = `CLKS_PER_BIT`/2. Bit-cycle counter `cnt` is $clog2(`CLKS_PER_BIT`) bits. `bit_cnt` is 3 bits; `shift_reg` is 8 bits.
- **IDLE:** when `rxs`=0, go to START with `cnt`=0.
- **START:** `cnt` increments each cycle. At `cnt`=HALF-1:
  - if `rxs`=0, go to DATA with `cnt`=0 and `bit_cnt`=0;
  - else treat it as a glitch and return to IDLE with no output.
- **DATA:** at `cnt`=`CLKS_PER_BIT`-1:
  - shift in: `shift_reg` <= {`rxs`, `shift_reg`[7:1]};
  - clear `cnt`;
  - increment `bit_cnt`; after the sample with `bit_cnt`=7, go to STOP.
- **STOP:** at `cnt`=`CLKS_PER_BIT`-1, sample `rxs`:
  - 1: `data_out` <= `shift_reg`, pulse `valid`, go to IDLE.
  - 0: pulse `frame_err`, keep `data_out` unchanged, go to RECOVER.
- **RECOVER:** wait for `rxs`=1, then go to IDLE. A held-low (break) line must not retrigger reception.
- **Output strobes:** `valid` and `frame_err` are registered. They are never high together and are low in every cycle not listed above.
- **Reset:** asserting `rst_n` at any point, including mid-frame, immediately forces:
  - state=IDLE, sync flops=1, `data_out`=8'h00, `valid`=0, `frame_err`=0, `busy`=0;
  - `cnt`, `bit_cnt` and `shift_reg` cleared.
  - The partial byte is discarded. After release, reception waits for a fresh falling edge.

## Timing
- Let E0 be the first edge at which sync stage 1 captures 0.
- IDLE→START occurs at edge E0+2.
- START→DATA occurs at E0+2+HALF.
- Data bit k (k=0..7) is sampled at E0+2+HALF+(k+1)·`CLKS_PER_BIT`.
- The stop bit is sampled at E0+2+HALF+9·`CLKS_PER_BIT`. `valid` or `frame_err` is high for exactly the following cycle; state is IDLE in that same cycle.
- For the default `CLKS_PER_BIT`=16: `valid` is high in the cycle after edge E0+154.
- **Back-to-back frames:** a start bit arriving immediately after the stop-bit sample point is accepted. There is no dead time beyond the synchroniser delay.
- **`busy`:** registered from state. It rises the cycle after IDLE→START and falls the cycle after the return to IDLE.

## Structure
- **Shared package `uart_pkg`:**
  - state encodings IDLE, START, DATA, STOP (shared with the transmitter), plus RECOVER;
  - default `CLKS_PER_BIT`;
  - frame constants: 8 data bits, 1 stop bit.
- **Sub-module `uart_sync`:** a generic 2-flop synchroniser with reset value 1, reused for other async inputs.
- **Core:** a single FSM with its counters, all in `uart_rx`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
1. Frame 0xA5 driven at 16 clk/bit → `data_out`=0xA5, `valid` high for 1 cycle at E0+155, `frame_err` never high, `busy` low afterwards.
2. Frames 0x00 then 0xFF back-to-back (no idle gap) → two `valid` pulses exactly 160 cycles apart, with `data_out` 0x00 then 0xFF.
3. `rx` low for 3 cycles, then high → returns to IDLE, no `valid`/`frame_err`, `data_out` unchanged; a following 0x3C frame is received correctly.
4. Frame 0x5A with the stop bit low, line held low for 100 cycles, then high, then frame 0x11 →
   - `frame_err` pulses once, `data_out` stays at its prior value, `busy` stays high while the line is low;
   - then `valid` with `data_out`=0x11.
5. `rst_n` asserted mid-frame during bit 4 of 0xC3 → all outputs return to reset values immediately; the rest of the frame produces no `valid`; the next 0x7E frame is received.
6. Frame 0x81 with ±1-cycle jitter on each bit edge → `data_out`=0x81, `valid` asserted (mid-bit sampling margin).
